// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder/subtractor with a valid/ready handshake.
// The operands are split into STAGES chunks of CW = WIDTH/STAGES bits. Stage k
// resolves chunk k using the carry registered by stage k-1. Operand chunks that
// are not yet processed, and result chunks that are already done, ride along
// in skew registers.
// Optional feature macro: ADD_PIPE_FLAGS_EN. When it is defined, the signed
// overflow and zero flags are registered in the final stage. When it is not
// defined, ovf and zero are tied low.
//
// Handshake: advance = !out_valid || out_ready, and in_ready = advance. When
// advance is low, every stage (data and valid) holds. A bundle is accepted on
// any edge where in_valid && in_ready. A result is consumed on any edge where
// out_valid && out_ready. Both can happen on the same edge.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Pipeline registers, one entry per stage. Entry k holds the output of stage k.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    // Stage inputs. These come from the ports for stage 0 and from the previous
    // stage's registers otherwise.
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];

    // Stage results: the chunk sum with its carry, and the partial result word
    // with the new chunk merged in.
    logic [CW:0]      sum_n [STAGES];
    logic [WIDTH-1:0] s_n   [STAGES];

    logic advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign res       = s_q[LAST];
    assign cout      = c_q[LAST];

    // Stage input selection. Subtraction is done as a + ~b + ~cin, so both the
    // operand B and the carry-in are inverted at the entry to stage 0.
    always_comb begin
        st_a[0] = a;
        st_b[0] = sub ? ~b : b;
        st_s[0] = '0;
        st_c[0] = sub ? ~cin : cin;
        st_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    // Each stage adds its own chunk and merges the result into the running word.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_n[k] = {1'b0, st_a[k][k*CW +: CW]}
                     + {1'b0, st_b[k][k*CW +: CW]}
                     + {{CW{1'b0}}, st_c[k]};
            s_n[k] = st_s[k];
            s_n[k][k*CW +: CW] = sum_n[k][CW-1:0];
        end
    end

    // Pipeline advance. The whole pipe moves or holds as one unit, so order is
    // preserved and bubbles move downstream without stalling the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= s_n[k];
                c_q[k] <= sum_n[k][CW];
                v_q[k] <= st_v[k];
            end
        end
    end

`ifdef ADD_PIPE_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Flags are computed together with the final chunk. The operand sign bits
    // reach this point through the skew registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                      (s_n[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
            zero_q <= (s_n[LAST] == '0);
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined integer adder/subtractor that generalises the combinational 32-bit carry-in/carry-out adder into a WIDTH-bit, STAGES-deep registered datapath with a valid/ready handshake and optional status flags. The operand is split into STAGES equal chunks, and each pipeline stage resolves one chunk's carry, so clock frequency scales with depth. It sits between the ALU operand registers and the result writeback, and it replaces the combinational adder wherever timing requires.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth, 1..WIDTH; chunk width CW = WIDTH/STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  operand bundle present.
- in_ready  out  1  block accepts the bundle this cycle.
- sub  in  1  0: add, 1: subtract.
- cin  in  1  carry-in (add) / borrow-in (sub).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result bundle present.
- out_ready  in  1  consumer takes the result this cycle.
- res  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- ovf  out  1  signed overflow (see Configuration).
- zero  out  1  res == 0 (see Configuration).

## Operation
- Add: res = a + b + cin, cout = carry out of bit WIDTH-1.
- Sub: res = a + ~b + ~cin = a − b − cin; cout = 1 means no borrow.
- Arithmetic is mod 2^WIDTH, unsigned bit patterns; ovf uses two's-complement interpretation: ovf = (A[msb] == B'[msb]) && (res[msb] != A[msb]), with B' = sub ? ~b : b.
- Stage k (0..STAGES-1) adds chunk k of A and B' using the carry registered by stage k-1 (stage 0 uses the effective carry-in). It registers the chunk sum, the carry, and a valid bit. Unprocessed upper chunks and already-computed lower chunks travel alongside in skew registers.
- Handshake: advance = !out_valid || out_ready; in_ready = advance. When advance = 0, the whole pipeline (data and valid bits) holds. A transfer occurs on an edge where in_valid && in_ready.
- Bubbles propagate as valid = 0 and do not stall upstream.
- res/cout/ovf/zero are meaningful only while out_valid = 1; they hold stable while out_valid && !out_ready.

## Timing
- Latency: a bundle accepted on edge t presents out_valid = 1 after edge t+STAGES-1 (STAGES clock edges including the accept edge), with no stall. STAGES = 1 gives a registered, one-cycle adder.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: each cycle with out_valid && !out_ready adds one cycle to every in-flight bundle's latency. Order is always preserved.
- in_ready is combinational from out_valid/out_ready; there is no combinational path from in_* to out_*.
- Reset: while rst = 1 at an edge, all stage valid bits clear. After that edge: out_valid = 0, in_ready = 1, res = 0, cout = 0, ovf = 0, zero = 0. In-flight bundles are discarded, and in_valid is ignored on the reset edge.
- Reset during a stall drops the held result; there is no partial output.
- Simultaneous accept and output on one edge is legal; both occur.

## Configuration
- ADD_PIPE_FLAGS_EN defined: ovf and zero are computed and registered in the final stage. The MSB sign bits travel with the pipeline.
- ADD_PIPE_FLAGS_EN undefined: ovf and zero are tied to 0 and the flag logic/registers are absent. The ports remain so the interface is unchanged.

## Test plan
- WIDTH=32, STAGES=4, add: a=0xAAAAAAAA, b=0x55555555, cin=0 → res=0xFFFFFFFF, cout=0, zero=0. With cin=1 → res=0x00000000, cout=1, zero=1. Each appears after exactly 4 edges.
- Add a=3, b=2, cin=1 → res=6, cout=0. Back-to-back with the two vectors above (3 consecutive cycles) → 3 consecutive out_valid cycles, in order.
- Sub a=5, b=7, cin=0 → res=0xFFFFFFFE, cout=0. Sub a=7, b=5, cin=1 → res=1, cout=1.
- Flags (macro on): 0x7FFFFFFF+1 → res=0x80000000, ovf=1. Sub 0x80000000−1 → 0x7FFFFFFF, ovf=1. With the macro off, ovf=zero=0 always.
- Stall: fill with 4 bundles, hold out_ready=0 for 5 cycles → in_ready=0 and res stable throughout. On release, all 4 results drain in order, one per cycle.
- Reset mid-flight with 3 bundles in the pipe → out_valid=0 on the next cycle and stays 0 for 4 cycles; no stale result. Repeat with STAGES=1 and WIDTH=8: 0xFF+0x01 → 0x00, cout=1, after 1 edge.
